alu_arbiter: RTL and testbench

Two-requester arbiter that time-shares the single ALUControl/ALU pair between the execute stage (port 0) and the branch/address unit (port 1). Each cycle it grants at most one request by round-robin, drives the winner's ALUop, FuncCode and operands into ALUControl and the ALU, and captures ALUResult, Zero and Overflow into a per-requester response slot held until the requester acknowledges it. It sits between the pipeline front-ends and the combinational ALU datapath.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_resp_slot.sv | 59 +++++
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: ALUop and FuncCode
// encodings, the response-slot state encoding and the perf counter helper.
package alu_pkg;

    // ALUop encodings as produced by the control unit
    localparam logic [3:0] ALU_OP_AND   = 4'b0000;
    localparam logic [3:0] ALU_OP_OR    = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD   = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB   = 4'b0110;
    localparam logic [3:0] ALU_OP_SLT   = 4'b0111;
    localparam logic [3:0] ALU_OP_NOR   = 4'b1100;
    localparam logic [3:0] ALU_OP_RTYPE = 4'b1111;

    // Driven on the shared ALU when nobody is granted; carries no side effects
    localparam logic [3:0] ALU_OP_IDLE  = 4'b0000;

    // R-type FuncCode values decoded by ALUControl when ALUop is RTYPE
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_NOR = 6'b100111;
    localparam logic [5:0] FUNC_SLT = 6'b101010;

    // Occupancy of a per-requester response slot
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int PERF_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
        if (value == {PERF_CNT_W{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/alu_resp_slot.sv
// Per-requester response holding register: captures the ALU result and
// flags on load and keeps them until the requester acknowledges.
// A load in the same cycle as an ack wins, so the slot stays full.
module alu_resp_slot
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] load_result,
    input  logic             load_zero,
    input  logic             load_ovf,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

    slot_state_t state;
    slot_state_t state_next;

    // Occupancy register, cleared asynchronously so in-flight results are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Load refills (or overwrites) the slot; an ack alone empties it
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = SLOT_FULL;
        end else if (ack) begin
            state_next = SLOT_EMPTY;
        end
    end

    // Payload capture; the value simply persists while no load occurs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            result <= load_result;
            zero   <= load_zero;
            ovf    <= load_ovf;
        end
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALUControl/ALU pair between the execute
// stage (port 0) and the branch/address unit (port 1). Results land in a
// per-port response slot held until acknowledged.
// Optional build macro ALU_ARB_PERF_EN adds saturating conflict/stall counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             ReqValid0,
    input  logic             ReqValid1,
    output logic             ReqReady0,
    output logic             ReqReady1,
    input  logic [3:0]       ReqALUop0,
    input  logic [3:0]       ReqALUop1,
    input  logic [5:0]       ReqFunc0,
    input  logic [5:0]       ReqFunc1,
    input  logic [WIDTH-1:0] ReqA0,
    input  logic [WIDTH-1:0] ReqB0,
    input  logic [WIDTH-1:0] ReqA1,
    input  logic [WIDTH-1:0] ReqB1,
    output logic             RespValid0,
    output logic             RespValid1,
    input  logic             RespAck0,
    input  logic             RespAck1,
    output logic [WIDTH-1:0] RespResult0,
    output logic [WIDTH-1:0] RespResult1,
    output logic             RespZero0,
    output logic             RespZero1,
    output logic             RespOvf0,
    output logic             RespOvf1,
    output logic [3:0]       AluOp,
    output logic [5:0]       AluFunc,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    input  logic [WIDTH-1:0] AluResult,
    input  logic             AluZero,
    input  logic             AluOvf
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]      ConflictCnt,
    output logic [15:0]      StallCnt0,
    output logic [15:0]      StallCnt1
`endif
);

    logic pri;
    logic pri_next;
    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;

    // Eligibility and round-robin grant; a port whose slot is full can only
    // win if it frees the slot with an ack in the same cycle
    always_comb begin
        elig0  = ReqValid0 && (!RespValid0 || RespAck0) && !Reset;
        elig1  = ReqValid1 && (!RespValid1 || RespAck1) && !Reset;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            grant0 = !pri;
            grant1 = pri;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
        pri_next = pri;
        if (grant0) begin
            pri_next = 1'b1;
        end else if (grant1) begin
            pri_next = 1'b0;
        end
    end

    // Priority pointer; reset favours port 0
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pri <= 1'b0;
        end else begin
            pri <= pri_next;
        end
    end

    assign ReqReady0 = grant0;
    assign ReqReady1 = grant1;

    // Shared datapath mux; idle cycles park on port 0 with a harmless ALUop
    always_comb begin
        AluOp   = ALU_OP_IDLE;
        AluFunc = ReqFunc0;
        AluA    = ReqA0;
        AluB    = ReqB0;
        if (Reset) begin
            AluFunc = '0;
            AluA    = '0;
            AluB    = '0;
        end else if (grant1) begin
            AluOp   = ReqALUop1;
            AluFunc = ReqFunc1;
            AluA    = ReqA1;
            AluB    = ReqB1;
        end else if (grant0) begin
            AluOp   = ReqALUop0;
        end
    end

    alu_resp_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk         (CLK),
        .rst         (Reset),
        .load        (grant0),
        .ack         (RespAck0),
        .load_result (AluResult),
        .load_zero   (AluZero),
        .load_ovf    (AluOvf),
        .valid       (RespValid0),
        .result      (RespResult0),
        .zero        (RespZero0),
        .ovf         (RespOvf0)
    );

    alu_resp_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk         (CLK),
        .rst         (Reset),
        .load        (grant1),
        .ack         (RespAck1),
        .load_result (AluResult),
        .load_zero   (AluZero),
        .load_ovf    (AluOvf),
        .valid       (RespValid1),
        .result      (RespResult1),
        .zero        (RespZero1),
        .ovf         (RespOvf1)
    );

`ifdef ALU_ARB_PERF_EN
    // Saturating counters of contended cycles and of per-port waiting cycles
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ConflictCnt <= '0;
            StallCnt0   <= '0;
            StallCnt1   <= '0;
        end else begin
            if (elig0 && elig1) begin
                ConflictCnt <= sat_inc(ConflictCnt);
            end
            if (ReqValid0 && !grant0) begin
                StallCnt0 <= sat_inc(StallCnt0);
            end
            if (ReqValid1 && !grant1) begin
                StallCnt1 <= sat_inc(StallCnt1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
// Optional build macro ALU_ARB_PERF_EN also checks the perf counters.
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             CLK;
    logic             Reset;
    logic             ReqValid0, ReqValid1;
    logic             ReqReady0, ReqReady1;
    logic [3:0]       ReqALUop0, ReqALUop1;
    logic [5:0]       ReqFunc0, ReqFunc1;
    logic [WIDTH-1:0] ReqA0, ReqB0, ReqA1, ReqB1;
    logic             RespValid0, RespValid1;
    logic             RespAck0, RespAck1;
    logic [WIDTH-1:0] RespResult0, RespResult1;
    logic             RespZero0, RespZero1, RespOvf0, RespOvf1;
    logic [3:0]       AluOp;
    logic [5:0]       AluFunc;
    logic [WIDTH-1:0] AluA, AluB;
    logic [WIDTH-1:0] AluResult;
    logic             AluZero, AluOvf;
`ifdef ALU_ARB_PERF_EN
    logic [15:0]      ConflictCnt, StallCnt0, StallCnt1;
`endif

    int nChecks = 0;
    int nFail   = 0;

    // Reference state: slot occupancy/contents per port and the priority bit
    bit          mFull [2];
    logic [31:0] mRes  [2];
    bit          mZero [2];
    bit          mOvf  [2];
    bit          mPri;
    bit          lastG0, lastG1;
`ifdef ALU_ARB_PERF_EN
    int          mConf, mStall0, mStall1;
`endif

    logic [3:0] opTable   [6];
    logic [5:0] funcTable [6];

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .ReqValid0   (ReqValid0),
        .ReqValid1   (ReqValid1),
        .ReqReady0   (ReqReady0),
        .ReqReady1   (ReqReady1),
        .ReqALUop0   (ReqALUop0),
        .ReqALUop1   (ReqALUop1),
        .ReqFunc0    (ReqFunc0),
        .ReqFunc1    (ReqFunc1),
        .ReqA0       (ReqA0),
        .ReqB0       (ReqB0),
        .ReqA1       (ReqA1),
        .ReqB1       (ReqB1),
        .RespValid0  (RespValid0),
        .RespValid1  (RespValid1),
        .RespAck0    (RespAck0),
        .RespAck1    (RespAck1),
        .RespResult0 (RespResult0),
        .RespResult1 (RespResult1),
        .RespZero0   (RespZero0),
        .RespZero1   (RespZero1),
        .RespOvf0    (RespOvf0),
        .RespOvf1    (RespOvf1),
        .AluOp       (AluOp),
        .AluFunc     (AluFunc),
        .AluA        (AluA),
        .AluB        (AluB),
        .AluResult   (AluResult),
        .AluZero     (AluZero),
        .AluOvf      (AluOvf)
`ifdef ALU_ARB_PERF_EN
        ,
        .ConflictCnt (ConflictCnt),
        .StallCnt0   (StallCnt0),
        .StallCnt1   (StallCnt1)
`endif
    );

    // Behavioural ALUControl+ALU: returns {result, zero, overflow}
    function automatic logic [33:0] aluRef(input logic [3:0] op, input logic [5:0] fn,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        logic [3:0]  eff;
        r   = '0;
        v   = 1'b0;
        eff = op;
        if (op == 4'b1111) begin
            case (fn)
                6'b100000: eff = 4'b0010;
                6'b100010: eff = 4'b0110;
                6'b100100: eff = 4'b0000;
                6'b100101: eff = 4'b0001;
                6'b100111: eff = 4'b1100;
                6'b101010: eff = 4'b0111;
                default:   eff = 4'b1111;
            endcase
        end
        case (eff)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0110: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            default: r = '0;
        endcase
        return {r, (r == 32'd0), v};
    endfunction

    // Stand-in for the external combinational ALU
    always_comb begin
        {AluResult, AluZero, AluOvf} = aluRef(AluOp, AluFunc, AluA, AluB);
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mFull[i] = 1'b0;
            mRes[i]  = '0;
            mZero[i] = 1'b0;
            mOvf[i]  = 1'b0;
        end
        mPri = 1'b0;
`ifdef ALU_ARB_PERF_EN
        mConf = 0; mStall0 = 0; mStall1 = 0;
`endif
    endtask

    // One clock: check the combinational grant/mux, clock, then check slots
    task automatic applyStimulus();
        logic [1:0]  v, ak, e;
        logic        g0, g1;
        logic [33:0] r0, r1;
        #2;
        v     = {ReqValid1, ReqValid0};
        ak    = {RespAck1, RespAck0};
        e[0]  = v[0] && (!mFull[0] || ak[0]);
        e[1]  = v[1] && (!mFull[1] || ak[1]);
        g0    = 1'b0;
        g1    = 1'b0;
        if (e[0] && e[1]) begin
            if (mPri) g1 = 1'b1; else g0 = 1'b1;
        end else begin
            g0 = e[0];
            g1 = e[1];
        end
        checkOutput("ready0", ReqReady0, g0);
        checkOutput("ready1", ReqReady1, g1);
        if (g0) begin
            checkOutput("aluop0", AluOp, ReqALUop0);
            checkOutput("alufunc0", AluFunc, ReqFunc0);
            checkOutput("aluA0", AluA, ReqA0);
            checkOutput("aluB0", AluB, ReqB0);
        end else if (g1) begin
            checkOutput("aluop1", AluOp, ReqALUop1);
            checkOutput("alufunc1", AluFunc, ReqFunc1);
            checkOutput("aluA1", AluA, ReqA1);
            checkOutput("aluB1", AluB, ReqB1);
        end else begin
            checkOutput("aluop_idle", AluOp, 32'd0);
        end
        r0 = aluRef(ReqALUop0, ReqFunc0, ReqA0, ReqB0);
        r1 = aluRef(ReqALUop1, ReqFunc1, ReqA1, ReqB1);
`ifdef ALU_ARB_PERF_EN
        if (e[0] && e[1] && mConf < 65535) mConf++;
        if (v[0] && !g0 && mStall0 < 65535) mStall0++;
        if (v[1] && !g1 && mStall1 < 65535) mStall1++;
`endif
        @(posedge CLK);
        if (g0) begin
            mFull[0] = 1'b1;
            {mRes[0], mZero[0], mOvf[0]} = r0;
        end else if (ak[0]) begin
            mFull[0] = 1'b0;
        end
        if (g1) begin
            mFull[1] = 1'b1;
            {mRes[1], mZero[1], mOvf[1]} = r1;
        end else if (ak[1]) begin
            mFull[1] = 1'b0;
        end
        if (g0) mPri = 1'b1;
        else if (g1) mPri = 1'b0;
        lastG0 = g0;
        lastG1 = g1;
        #1;
        checkOutput("respvalid0", RespValid0, mFull[0]);
        checkOutput("respvalid1", RespValid1, mFull[1]);
        if (mFull[0]) begin
            checkOutput("result0", RespResult0, mRes[0]);
            checkOutput("zero0", RespZero0, mZero[0]);
            checkOutput("ovf0", RespOvf0, mOvf[0]);
        end
        if (mFull[1]) begin
            checkOutput("result1", RespResult1, mRes[1]);
            checkOutput("zero1", RespZero1, mZero[1]);
            checkOutput("ovf1", RespOvf1, mOvf[1]);
        end
`ifdef ALU_ARB_PERF_EN
        checkOutput("conflict_cnt", ConflictCnt, mConf);
        checkOutput("stall_cnt0", StallCnt0, mStall0);
        checkOutput("stall_cnt1", StallCnt1, mStall1);
`endif
    endtask

    task automatic randomRequest(input int port);
        int k;
        logic [31:0] a, b;
        k = $urandom_range(0, 5);
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        if (port == 0) begin
            ReqValid0 = 1'b1; ReqALUop0 = opTable[k];
            ReqFunc0 = funcTable[$urandom_range(0, 5)]; ReqA0 = a; ReqB0 = b;
        end else begin
            ReqValid1 = 1'b1; ReqALUop1 = opTable[k];
            ReqFunc1 = funcTable[$urandom_range(0, 5)]; ReqA1 = a; ReqB1 = b;
        end
    endtask

    initial begin
        opTable   = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1111};
        funcTable = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
        Reset = 1'b1;
        ReqValid0 = 0; ReqValid1 = 0; RespAck0 = 0; RespAck1 = 0;
        ReqALUop0 = '0; ReqALUop1 = '0; ReqFunc0 = '0; ReqFunc1 = '0;
        ReqA0 = '0; ReqB0 = '0; ReqA1 = '0; ReqB1 = '0;
        modelReset();

        // Reset values
        #1;
        checkOutput("rst_ready0", ReqReady0, 0);
        checkOutput("rst_ready1", ReqReady1, 0);
        checkOutput("rst_respvalid0", RespValid0, 0);
        checkOutput("rst_respvalid1", RespValid1, 0);
        checkOutput("rst_result0", RespResult0, 0);
        checkOutput("rst_result1", RespResult1, 0);
        checkOutput("rst_aluop", AluOp, 0);
        checkOutput("rst_alufunc", AluFunc, 0);
        checkOutput("rst_aluA", AluA, 0);
        checkOutput("rst_aluB", AluB, 0);
        @(posedge CLK); @(posedge CLK); #1;
        Reset = 1'b0;

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("idle_aluA", AluA, 0);
        checkOutput("idle_result0", RespResult0, 0);

        // Port 0 alone: ADD 5+7, held until ack
        $display("[TB] port 0 single ADD");
        ReqValid0 = 1; ReqALUop0 = 4'b1111; ReqFunc0 = 6'b100000; ReqA0 = 5; ReqB0 = 7;
        applyStimulus();
        ReqValid0 = 0;
        checkOutput("add_result0", RespResult0, 12);
        checkOutput("add_zero0", RespZero0, 0);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("add_held0", RespResult0, 12);
        RespAck0 = 1;
        applyStimulus();
        RespAck0 = 0;

        // Both ports continuously with immediate acks
        $display("[TB] alternating grants");
        ReqValid0 = 1; ReqALUop0 = 4'b1111; ReqFunc0 = 6'b100010; ReqA0 = 9; ReqB0 = 9;
        ReqValid1 = 1; ReqALUop1 = 4'b1111; ReqFunc1 = 6'b100101; ReqA1 = 32'hF0; ReqB1 = 32'h0F;
        RespAck0 = 1; RespAck1 = 1;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("alt_result1", RespResult1, 32'hFF);
        checkOutput("alt_zero0", RespZero0, 1);

        // Port 1 blocked by its own unacked slot
        $display("[TB] port 1 blocked by full slot");
        ReqValid0 = 0; RespAck1 = 1;
        applyStimulus();
        RespAck1 = 0; ReqValid0 = 1; ReqA1 = 32'h3; ReqB1 = 32'h30;
        for (int i = 0; i < 3; i++) applyStimulus();
        ReqValid0 = 0; RespAck1 = 1;
        applyStimulus();
        checkOutput("overwrite_valid1", RespValid1, 1);
        checkOutput("overwrite_result1", RespResult1, 32'h33);
        RespAck0 = 0; RespAck1 = 0; ReqValid1 = 0;
        applyStimulus();

        // Signed overflow on port 1
        $display("[TB] overflow on port 1");
        RespAck1 = 1; ReqValid1 = 1; ReqALUop1 = 4'b1111; ReqFunc1 = 6'b100000;
        ReqA1 = 32'h7FFF_FFFF; ReqB1 = 32'h1;
        applyStimulus();
        ReqValid1 = 0; RespAck1 = 0;
        checkOutput("ovf_flag1", RespOvf1, 1);
        checkOutput("ovf_result1", RespResult1, 32'h8000_0000);

        // Reset while both slots are full and a grant is pending
        $display("[TB] reset mid-operation");
        ReqValid0 = 1; ReqA0 = 1; ReqB0 = 2; ReqFunc0 = 6'b100000; RespAck0 = 1;
        applyStimulus();
        ReqValid0 = 1; ReqValid1 = 1; RespAck0 = 1; RespAck1 = 1;
        #2;
        Reset = 1'b1;
        #1;
        modelReset();
        checkOutput("midrst_respvalid0", RespValid0, 0);
        checkOutput("midrst_respvalid1", RespValid1, 0);
        checkOutput("midrst_ready0", ReqReady0, 0);
        checkOutput("midrst_ready1", ReqReady1, 0);
        @(posedge CLK); #1;
        Reset = 1'b0; RespAck0 = 0; RespAck1 = 0;
        applyStimulus();
        checkOutput("post_rst_respvalid0", RespValid0, 1);
        checkOutput("post_rst_respvalid1", RespValid1, 0);

        // Randomized traffic; requests stay stable until accepted
        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            if (!ReqValid0 || lastG0) begin
                if ($urandom_range(0, 9) < 6) randomRequest(0); else ReqValid0 = 0;
            end
            if (!ReqValid1 || lastG1) begin
                if ($urandom_range(0, 9) < 6) randomRequest(1); else ReqValid1 = 0;
            end
            RespAck0 = 1'($urandom_range(0, 1));
            RespAck1 = 1'($urandom_range(0, 1));
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
